vector_driver: RTL

VECTOR_DRIVER -- requirements
Module: vector_driver

---
 rtl/vector_driver_pkg.sv | 15 +
 rtl/vector_fifo.sv | 56 +++++
 rtl/vector_driver.sv | 109 ++++++++++
 3 files changed

// File: rtl/vector_driver_pkg.sv
// rtl/vector_driver_pkg.sv - shared widths, word type and FSM states for vector_driver
package vector_driver_pkg;

    localparam int V1_W   = 2;
    localparam int V2_W   = 6;
    localparam int WORD_W = V1_W + V2_W;

    typedef logic [0:WORD_W-1] word_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/vector_fifo.sv
// rtl/vector_fifo.sv - DEPTH-entry word FIFO with wrap-around pointers and occupancy count
module vector_fifo
    import vector_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  word_t wdata,
    input  logic  pop,
    output word_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    word_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vector_driver.sv
// rtl/vector_driver.sv - buffers words and drives them onto two fields, holding each for HOLD cycles
module vector_driver
    import vector_driver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:7]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [0:1]  vector1,
    output logic [0:5]  vector2,
    output logic        out_strobe,
    output logic        empty,
    output logic [0:7]  sent_count
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t        state;
    state_t        state_nx;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nx;
    logic          ready_en;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    word_t         fifo_rdata;

    // A full FIFO refuses the word even when a pop frees a slot on the same edge.
    assign in_ready = ready_en & ~fifo_full;
    assign push     = in_valid & in_ready;
    assign empty    = fifo_empty & (state == S_IDLE);

    vector_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
        end
    end

    // HOLD leaves on the edge that takes the counter to zero, so a word occupies exactly HOLD cycles.
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    hold_nx  = HW'(HOLD - 1);
                    state_nx = (HOLD > 1) ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                if (hold_cnt != '0) begin
                    hold_nx = hold_cnt - HW'(1);
                end
                if (hold_cnt <= HW'(1)) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        if (state == S_IDLE && !fifo_empty) begin
            pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            vector1    <= '0;
            vector2    <= '0;
            out_strobe <= 1'b0;
            sent_count <= '0;
        end else begin
            ready_en   <= 1'b1;
            out_strobe <= pop;
            if (pop) begin
                vector1    <= fifo_rdata[0:V1_W-1];
                vector2    <= fifo_rdata[V1_W:WORD_W-1];
                sent_count <= sent_count + 8'd1;
            end
        end
    end

endmodule
